// File: rtl/aes_out_serializer.sv
// Buffers 128-bit AES result blocks and streams them to the AXI side as 32-bit words, word 0 first.
// Optional build macro AES_SER_BYTESWAP_EN presents each word big-endian instead of little-endian.
module aes_out_serializer #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [15:0][7:0] inp_ser,
    input  logic             wr_en,
    input  logic             rd_ready,
    output logic [31:0]      outp_ser,
    output logic             outp_valid,
    output logic             outp_last,
    output logic             buf_full,
    output logic             buf_empty,
    output logic             ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [15:0][7:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       wcnt_q, wcnt_d;
    logic [0:0]       state_q, state_d;
    logic             ovf_q, ovf_d;
    logic             pop, pop_last, wr_acc;
    logic [127:0]     rd_blk;
    logic [31:0]      rd_word;

    function automatic logic [31:0] order_word(input logic [31:0] w);
`ifdef AES_SER_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    assign outp_valid = (state_q == ST_SEND);
    assign outp_last  = outp_valid && (wcnt_q == 2'd3);
    assign buf_full   = (cnt_q == FULL_CNT);
    assign buf_empty  = (cnt_q == '0);
    assign ovf        = ovf_q;

    assign rd_blk   = mem_q[rd_ptr_q];
    assign rd_word  = rd_blk[{wcnt_q, 5'b0} +: 32];
    assign outp_ser = outp_valid ? order_word(rd_word) : 32'h0;

    // A write into a full buffer still lands when the head block leaves in the same cycle.
    assign pop      = outp_valid && rd_ready;
    assign pop_last = pop && (wcnt_q == 2'd3);
    assign wr_acc   = wr_en && (!buf_full || pop_last);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wcnt_d   = wcnt_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q + CNT_W'(wr_acc) - CNT_W'(pop_last);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else if (wr_en) begin
            ovf_d = 1'b1;
        end
        if (pop) begin
            wcnt_d = wcnt_q + 2'd1;
        end
        if (pop_last) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        state_d = (cnt_d != '0) ? ST_SEND : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end

    // Block storage carries no reset; pointers and occupancy define what is live.
    always_ff @(posedge clk) begin
        if (!resetn && wr_acc) begin
            mem_q[wr_ptr_q] <= inp_ser;
        end
    end

endmodule

// File: doc/aes_out_serializer.md
AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of 128-bit result blocks buffered (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: synchronous reset, active-high (asserted = 1).
REQ-004 SHALL have port inp_ser, input, [15:0][7:0]: the encrypted block from the encryption core's outAES.
REQ-005 SHALL have port wr_en, input, 1 bit: one-cycle block-valid pulse, driven by the core's ctrl_dataOut.
REQ-006 SHALL have port rd_ready, input, 1 bit: the AXI-side reader accepts the current word.
REQ-007 SHALL have port outp_ser, output, 32 bits: the current output word.
REQ-008 SHALL have port outp_valid, output, 1 bit: outp_ser holds a valid word.
REQ-009 SHALL have port outp_last, output, 1 bit: the current word is word 3 of its block.
REQ-010 SHALL have port buf_full, output, 1 bit: DEPTH blocks are stored.
REQ-011 SHALL have port buf_empty, output, 1 bit: no blocks are stored.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag set when a block is dropped.

Function
REQ-013 SHALL store blocks in a circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits each, wrapping modulo DEPTH, plus an occupancy counter of 0..DEPTH.
REQ-014 SHALL capture inp_ser on any clock edge where wr_en=1 and the buffer is not full, or is full but a final-word pop happens in the same cycle.
REQ-015 SHALL drop a write made while full with no simultaneous pop, leave the buffer unchanged, and set ovf=1 until reset.
REQ-016 SHALL use a two-state FSM: IDLE (buffer empty, outp_valid=0) and SEND (buffer non-empty, outp_valid=1).
REQ-017 SHALL move IDLE->SEND on an accepted write, and SEND->IDLE when word 3 of the last stored block is popped with no simultaneous write.
REQ-018 SHALL assert outp_valid on the cycle after a write into an empty buffer (latency 1 clock).
REQ-019 SHALL maintain a 2-bit word counter wcnt, reset to 0, that increments on each handshake (outp_valid && rd_ready) and wraps 3->0.
REQ-020 SHALL release the block at rd_ptr and advance rd_ptr when a handshake occurs with wcnt=3.
REQ-021 SHALL form outp_ser for wcnt=k as {byte[4k+3], byte[4k+2], byte[4k+1], byte[4k]} of the block at rd_ptr.
REQ-022 SHALL hold outp_ser and wcnt stable while outp_valid=1 and rd_ready=0.
REQ-023 SHALL drive outp_last = outp_valid && (wcnt==3).
REQ-024 SHALL, when a write and a pop occur in the same cycle, perform both, leaving occupancy unchanged.
REQ-025 SHALL keep rd_ready ignored while outp_valid=0, with no change to wcnt.
REQ-026 SHALL sustain one word per clock under continuous rd_ready=1.

Reset
REQ-027 SHALL, with resetn=1 at a clock edge, clear pointers, occupancy, wcnt and ovf, and enter IDLE, regardless of any transfer in progress.
REQ-028 SHALL drive these reset values: outp_valid=0, outp_last=0, buf_empty=1, buf_full=0, ovf=0, outp_ser=0.
REQ-029 SHALL ignore wr_en and rd_ready in any cycle where resetn=1.

Configuration
REQ-030 SHALL, when macro AES_SER_BYTESWAP_EN is defined, present each word big-endian as {byte[4k], byte[4k+1], byte[4k+2], byte[4k+3]}.
REQ-031 SHALL, when AES_SER_BYTESWAP_EN is undefined, use the REQ-021 ordering; all other behaviour is identical in both builds.

Verification
REQ-032 SHALL cover the FIPS-197 AES-256 vector: write block 8ea2b7ca516745bfeafc49904b496089 (byte0=0x8e) with rd_ready=1 -> words 0xcab7a28e, 0xbf456751, 0x9049fcea, 0x8960494b on 4 consecutive cycles, outp_last on the 4th, then buf_empty=1.
REQ-033 SHALL cover backpressure: rd_ready=0 for 5 cycles after a write -> outp_ser=0xcab7a28e and wcnt=0 held, outp_valid=1 throughout.
REQ-034 SHALL cover overflow with DEPTH=2: three writes, no reads -> buf_full=1 after the 2nd, 3rd block dropped, ovf=1, and first two blocks read out intact.
REQ-035 SHALL cover simultaneous full write and final pop: full buffer, write in the cycle word 3 is popped -> ovf=0, occupancy stays 2, new block read out last.
REQ-036 SHALL cover mid-block reset: resetn=1 after 2 words are read -> next cycle outp_valid=0, buf_empty=1; a new block then starts at word 0.
REQ-037 SHALL cover the byte-swap build: rerun REQ-032 with AES_SER_BYTESWAP_EN defined -> first word 0x8ea2b7ca.
